noc_param_fifo: RTL
===================

NOC_PARAM_FIFO -- requirements
Module: noc_param_fifo

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..512.
REQ-002 Parameter ADDR_W, default 5: address bits; depth DEPTH = 2**ADDR_W, legal range 1..10.
REQ-003 Parameter AF_LEVEL, default 2**ADDR_W - 2: almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  synchronous discard of all stored entries.
REQ-008 in_valid  in  1  producer offers in_data.
REQ-009 in_ready  out  1  FIFO can accept; push = in_valid & in_ready.
REQ-010 in_data  in  WIDTH  write payload.
REQ-011 out_valid  out  1  out_data holds the head entry.
REQ-012 out_ready  in  1  consumer accepts; pop = out_valid & out_ready.
REQ-013 out_data  out  WIDTH  head payload (first-word-fall-through); all-zero when out_valid=0.
REQ-014 count  out  ADDR_W+1  current occupancy, 0..DEPTH.
REQ-015 almost_full  out  1  threshold flag per REQ-003.
REQ-016 almost_empty  out  1  threshold flag per REQ-004.
REQ-017 peak  out  ADDR_W+1  high-water mark of count since the last reset or flush.

Function
REQ-018 Storage SHALL be a DEPTH x WIDTH array with write and read pointers of ADDR_W+1 bits; the MSB distinguishes the full condition from the empty condition on wrap-around.
REQ-019 in_ready SHALL be 1 whenever count < DEPTH, and also when count == DEPTH with out_ready=1 (simultaneous pop frees a slot); in_ready SHALL be 0 while reset or flush is high.
REQ-020 out_valid SHALL equal (count != 0), combinationally from registered state, except as extended by REQ-033.
REQ-021 A push SHALL write in_data at the write pointer and increment that pointer modulo 2**(ADDR_W+1); the data becomes visible on out_data no earlier than the next cycle.
REQ-022 A pop SHALL increment the read pointer; the next entry appears on out_data in the following cycle, giving zero-bubble back-to-back reads.
REQ-023 count SHALL be registered: next = count + push - pop; a simultaneous push and pop leaves count unchanged.
REQ-024 almost_full and almost_empty SHALL be combinational from the registered count.
REQ-025 peak SHALL register max(peak, next count) every cycle.
REQ-026 flush SHALL, on the clock edge, zero both pointers, count and peak; push and pop are ignored that cycle; storage contents are not cleared.
REQ-027 in_valid with in_ready=0 SHALL leave all state unchanged (backpressure, not an error); out_ready with out_valid=0 SHALL leave all state unchanged.
REQ-028 in_data SHALL be sampled only on push; the producer SHALL hold in_valid/in_data until accepted (protocol rule, checked by assertion).

Reset
REQ-029 While reset=1 at a rising edge: pointers, count and peak SHALL become 0; storage SHALL NOT be cleared.
REQ-030 After reset: in_ready=1, out_valid=0, out_data=0, count=0, peak=0, almost_full=0, almost_empty=1.
REQ-031 reset asserted mid-transfer SHALL discard any push or pop in that cycle; reset SHALL take priority over flush.

Configuration
REQ-032 Macro NOC_FIFO_BYPASS_EN SHALL compile in the empty-FIFO bypass path; without it, the latency from push to out_valid is always 1 cycle.
REQ-033 With NOC_FIFO_BYPASS_EN defined and count==0, in_valid=1, out_ready=1: out_valid=1, out_data=in_data in the same cycle; the beat is consumed without a write; pointers, count and peak are unchanged.
REQ-034 With NOC_FIFO_BYPASS_EN defined and count==0, in_valid=1, out_ready=0: out_valid SHALL stay 0 and the beat is stored normally.

Verification
REQ-035 Fill: after reset, push 32 beats 0x0..0x1F with out_ready=0 -> in_ready=0, count=32, almost_full=1 from count 30, peak=32.
REQ-036 Full with simultaneous push and pop: at count=32 drive in_valid=1, out_ready=1 -> head 0x0 popped, new beat written, count stays 32, no data lost across pointer wrap.
REQ-037 Drain and order: pop all -> out_data sequence 0x0..0x1F with no bubbles; count=0, out_valid=0, out_data=0, almost_empty=1.
REQ-038 Flush mid-stream: at count=10 pulse flush with in_valid=1 -> next cycle count=0, peak=0, out_valid=0; the offered beat is not stored.
REQ-039 Bypass (macro defined): empty FIFO, in_valid=1, in_data=0xA5A5A5A5, out_ready=1 -> out_valid=1, out_data=0xA5A5A5A5 in the same cycle; count stays 0. Macro undefined -> out_valid=0 that cycle, out_valid=1 the next.
REQ-040 Reset mid-operation: at count=7 assert reset with in_valid=1, out_ready=1 -> next cycle count=0, peak=0, in_ready=1, out_valid=0.

Source files
------------

// File: rtl/noc_param_fifo.sv
// noc_param_fifo -- parameterised first-word-fall-through FIFO for NoC links.
//
// Ports:
//   clk           single clock, all state updates on the rising edge
//   reset         synchronous, active-high; clears pointers, count and peak
//   flush         synchronous discard of all stored entries
//   in_valid      producer offers in_data
//   in_ready      FIFO can accept this cycle (push = in_valid & in_ready)
//   in_data       write payload, WIDTH bits
//   out_valid     out_data holds the head entry
//   out_ready     consumer accepts (pop = out_valid & out_ready)
//   out_data      head payload, forced to zero while out_valid is low
//   count         current occupancy, 0..DEPTH
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   peak          high-water mark of count since the last reset or flush
//
// Build option:
//   NOC_FIFO_BYPASS_EN  when defined, a beat offered to an empty FIFO while
//                       the consumer is ready passes straight through in the
//                       same cycle without touching storage.

module noc_param_fifo #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int AF_LEVEL = (2 ** ADDR_W) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W:0]   count,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   peak
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] AF_C   = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C   = (ADDR_W + 1)'(AE_LEVEL);
    // Pointer difference pattern that marks a full FIFO: MSBs differ,
    // lower address bits match.
    localparam logic [ADDR_W:0] FULL_X = {1'b1, {ADDR_W{1'b0}}};

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;

    logic              empty;
    logic              full;
    logic              bypass;
    logic              push_store;
    logic              pop;
    logic [ADDR_W:0]   count_nxt;
    logic [ADDR_W:0]   peak_nxt;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == FULL_X);

    // A full FIFO can still take a beat when the head leaves the same cycle.
    assign in_ready = !reset && !flush && (!full || out_ready);

`ifdef NOC_FIFO_BYPASS_EN
    assign bypass = empty && in_valid && in_ready && out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed beat goes straight to the consumer and is never written.
    assign push_store = in_valid && in_ready && !bypass;
    assign pop        = !empty && out_ready && !reset && !flush;

    assign out_valid = !empty || bypass;

    always_comb begin
        out_data = '0;
        if (bypass) begin
            out_data = in_data;
        end else if (!empty) begin
            out_data = mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    always_comb begin
        count_nxt = count;
        case ({push_store, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    assign peak_nxt = (count_nxt > peak) ? count_nxt : peak;

    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Control state: reset wins over flush, both discard this cycle's traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            peak   <= '0;
        end else begin
            if (push_store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            peak  <= peak_nxt;
        end
    end

    // Storage is never cleared; only accepted beats are written.
    always_ff @(posedge clk) begin
        if (push_store) begin
            mem[wr_ptr[ADDR_W-1:0]] <= in_data;
        end
    end

    // Producer must hold an unaccepted beat stable until it is taken.
    a_hold_beat : assert property (@(posedge clk) disable iff (reset)
        (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_data)));

endmodule
